mux_4_1_rr_arbiter: RTL
=======================

# mux_4_1_rr_arbiter

Round-robin arbiter and output register that shares one 4:1 data mux between four valid/ready requesters. Each cycle it selects one requesting input by rotating priority, drives the mux select, and registers the chosen word into a one-entry output stage with its own valid/ready handshake. It sits in front of any single-consumer datapath fed by four independent producers.

## Interface

- `W`, default 4: data width of every input and of the output.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 4: bit i set means requester i offers `d<i>`.
- `in_ready` output 4: bit i set means requester i's word is accepted this cycle; at most one bit set.
- `d0`, `d1`, `d2`, `d3` input W each: requester data words.
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: consumer accepts the output word this cycle.
- `out_data` output W: registered selected word.
- `out_src` output 2: index of the requester that supplied `out_data`.

## Operation

- Output stage has two states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `can_load` = EMPTY, or FULL with `out_ready`=1.
- Priority pointer `last` (2 bits) holds the index of the most recent winner.
  - Search order is last+1, last+2, last+3, last, all mod 4.
  - Winner `sel` = first index in that order with `in_valid` set.
- `in_ready[sel]` = `can_load` and any `in_valid` set. All other `in_ready` bits are 0. `in_ready` is combinational from `in_valid`, `last`, state and `out_ready`.
- On an accept (`|in_valid` and `can_load`):
  - `out_data` <= selected data via a 4:1 case mux on `sel`.
  - `out_src` <= `sel`.
  - `last` <= `sel`.
  - Next state is FULL.
- FULL with `out_ready`=1 and no `in_valid`: next state is EMPTY. `out_data` and `out_src` keep their values.
- FULL with `out_ready`=0: `out_data`, `out_src` and `last` hold. All `in_ready` bits are 0.
- EMPTY with no `in_valid`: no change.
- `last` updates only on an accept. It does not update on idle cycles or stalls.
- Requesters are not required to hold `in_valid` while not granted. Arbitration is re-evaluated every cycle from the current `in_valid`.
- A single persistent requester gets every accept. Four persistent requesters are served in the order 0,1,2,3,0,… after reset.

## Timing

- Reset values:
  - `out_valid` 0.
  - `out_data` 0.
  - `out_src` 0.
  - `last` 3, so index 0 has first priority.
  - `in_ready` 0 during and in the cycle of reset.
- `rst` overrides every other input in the same edge. Reset in FULL discards the held word. No accept occurs in a cycle with `rst`=1.
- Latency: a word accepted at edge N is visible on `out_data`/`out_valid` after edge N, one cycle.
- Throughput: one word per cycle when `out_ready` is held at 1. A simultaneous unload and load in FULL keeps `out_valid`=1 with no bubble.
- While FULL and `out_ready`=0, `out_data`, `out_src` and `out_valid` are stable.
- There is no combinational path from `in_valid`/`d*` to `out_*`. The only combinational path from `out_ready` is to `in_ready`.

## Test plan

- Reset then idle: `rst`=1 for 2 cycles, then `in_valid`=0 for 5 cycles. Required: `out_valid`=0, `out_data`=0, `out_src`=0 and `in_ready`=0 throughout.
- Round robin: `in_valid`=4'b1111, d0..d3=4'hA,4'hB,4'hC,4'hD, `out_ready`=1. Required:
  - Accepts in order 0,1,2,3,0.
  - `out_src` 0,1,2,3,0 on consecutive cycles starting one cycle after the first accept.
  - `out_data` A,B,C,D,A on those same cycles.
  - Exactly one `in_ready` bit set per cycle.
- Backpressure: accept d2=4'h5 from `in_valid`=4'b0100, then `out_ready`=0 for 4 cycles with `in_valid`=4'b1011. Required:
  - `out_data`=5 and `out_src`=2 stable for those 4 cycles.
  - `in_ready`=0 for those 4 cycles.
  - When `out_ready` rises, index 3 is granted, since `last`=2.
- Skip and wrap: after reset, `in_valid`=4'b1000, d3=4'h7. Required: `in_ready`=4'b1000, then `out_src`=3, `out_data`=7. Next `in_valid`=4'b1001: index 0 is granted.
- Drain to EMPTY: single accept of d1=4'h9 with `out_ready`=1 and no further requests. Required: `out_valid`=1 for exactly one cycle, then 0; `out_data` stays 9.
- Mid-operation reset: FULL with `out_ready`=0, assert `rst` for one cycle with `in_valid`=4'b1111. Required:
  - Next cycle `out_valid`=0 and `out_data`=0.
  - `in_ready`=0 during the `rst` cycle.
  - First grant after reset goes to index 0.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter for four valid/ready requesters sharing one 4:1 data mux,
// feeding a one-entry registered output stage with its own valid/ready handshake.
module mux_4_1_rr_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   r_state;
    logic [1:0]   r_last;
    logic [W-1:0] r_data;
    logic [1:0]   r_src;

    logic         w_can_load;
    logic         w_any_valid;
    logic         w_accept;
    logic [1:0]   w_sel;
    logic         w_found;
    logic [W-1:0] w_mux_data;
    logic [1:0]   w_cand [4];

    // Candidate k is the (k+1)-th index after the last winner; the 2-bit add wraps mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand[gi] = r_last + 2'(gi + 1);
        end
    endgenerate

    always_comb begin
        w_sel   = r_last;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && in_valid[w_cand[k]]) begin
                w_sel   = w_cand[k];
                w_found = 1'b1;
            end
        end
    end

    assign w_can_load  = (r_state == ST_EMPTY) || out_ready;
    assign w_any_valid = |in_valid;
    // Reset suppresses the grant in its own cycle so no word is ever accepted then.
    assign w_accept    = w_any_valid && w_can_load && !rst;

    always_comb begin
        in_ready = 4'b0000;
        if (w_accept) begin
            in_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        case (w_sel)
            2'd0:    w_mux_data = d0;
            2'd1:    w_mux_data = d1;
            2'd2:    w_mux_data = d2;
            default: w_mux_data = d3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_last  <= 2'd3;
            r_data  <= '0;
            r_src   <= 2'd0;
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_last  <= w_sel;
            r_data  <= w_mux_data;
            r_src   <= w_sel;
        end else if (r_state == ST_FULL && out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule
